// File: rtl/logic_block_pkg.sv
// logic_block_pkg: shared width and mode encodings for the registered ALU
package logic_block_pkg;
  localparam int WIDTH = 8;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_AND = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit gate-level adder used in the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/logic_block_s.sv
// logic_block_s: structural ALU, ripple-carry adder plus per-bit gates and mux
module logic_block_s
  import logic_block_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic [1:0]       m,
  output logic [WIDTH-1:0] W,
  output logic             Co
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx, s, nw;
  logic             nco;
  assign c[0] = Ci;
  // inverting B turns the adder into A + ~B + Ci for subtraction
  assign bx = B ^ {WIDTH{m == MODE_SUB}};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder fa (.a(A[i]), .b(bx[i]), .c(c[i]), .s(s[i]), .co(c[i+1]));
    assign nw[i] = m[1] ? (m[0] ? A[i] ^ B[i] : A[i] & B[i]) : s[i];
  end
  assign nco = ~m[1] & c[WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {Co, W} <= '0;
    else {Co, W} <= {nco, nw};
endmodule

// File: rtl/logic_block.sv
// logic_block: behavioural 8-bit registered add/sub/and/xor unit
module logic_block
  import logic_block_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic [1:0]       m,
  output logic [WIDTH-1:0] W,
  output logic             Co
);
  logic [WIDTH:0] nxt;
  always_comb begin
    nxt = '0;
    case (m)
      MODE_ADD: nxt = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Ci};
      MODE_SUB: nxt = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, Ci};
      MODE_AND: nxt = {1'b0, A & B};
      MODE_XOR: nxt = {1'b0, A ^ B};
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {Co, W} <= '0;
    else {Co, W} <= nxt;
endmodule

// File: tb/tb_logic_block.sv
// tb_logic_block: drives both ALU variants and scores them against a model
module tb_logic_block;
  import logic_block_pkg::*;
  logic       clk = 0, rst_n = 0, Ci = 0;
  logic [7:0] A = 0, B = 0, W, W_s;
  logic [1:0] m = 0;
  logic       Co, Co_s;
  int         checks = 0, errors = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  logic_block   dut   (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Ci(Ci), .m(m), .W(W), .Co(Co));
  logic_block_s dut_s (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Ci(Ci), .m(m), .W(W_s), .Co(Co_s));

  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, logic ci, logic [1:0] mm);
    int s;
    if (mm == 2'b00) begin
      s = int'(a) + int'(b) + int'(ci);
      return s[8:0];
    end
    if (mm == 2'b01) begin
      s = int'(a) - int'(b) - 1 + int'(ci) + 256;
      return s[8:0];
    end
    return mm == 2'b10 ? {1'b0, a & b} : {1'b0, a ^ b};
  endfunction

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(string tag, logic [8:0] exp);
    chk({tag, "_beh"}, {Co, W}, exp);
    chk({tag, "_str"}, {Co_s, W_s}, exp);
  endtask

  task automatic step(string tag, logic [7:0] a, logic [7:0] b, logic ci, logic [1:0] mm);
    @(negedge clk);
    A = a; B = b; Ci = ci; m = mm;
    q.push_back(model(a, b, ci, mm));
    @(posedge clk);
    #1;
    chk_both(tag, q.pop_front());
  endtask

  initial begin
    #3;
    chk_both("reset", 9'h000);
    @(negedge clk);
    rst_n = 1;
    step("add1", 8'h3C, 8'h15, 1'b1, MODE_ADD);
    chk("add1_const", {Co, W}, 9'h052);
    step("add2", 8'hFF, 8'h01, 1'b0, MODE_ADD);
    chk("add2_const", {Co, W}, 9'h100);
    step("sub1", 8'h10, 8'h01, 1'b1, MODE_SUB);
    chk("sub1_const", {Co, W}, 9'h10F);
    step("sub2", 8'h01, 8'h02, 1'b1, MODE_SUB);
    chk("sub2_const", {Co, W}, 9'h0FF);
    step("sub_ci0", 8'h10, 8'h01, 1'b0, MODE_SUB);
    chk("sub_ci0_const", {Co, W}, 9'h10E);
    step("and", 8'hF0, 8'h3C, 1'b1, MODE_AND);
    chk("and_const", {Co, W}, 9'h030);
    step("xor", 8'hAA, 8'h0F, 1'b1, MODE_XOR);
    chk("xor_const", {Co, W}, 9'h0A5);
    step("pre_rst", 8'h80, 8'h80, 1'b1, MODE_ADD);
    #2;
    rst_n = 0;
    #1;
    chk_both("async_rst", 9'h000);
    @(negedge clk);
    A = 8'h12; B = 8'h34; Ci = 1; m = MODE_ADD;
    @(posedge clk);
    #1;
    chk_both("held_rst", 9'h000);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_both("post_release", 9'h000);
    step("first_after_rst", 8'h12, 8'h34, 1'b1, MODE_ADD);
    chk("first_const", {Co, W}, 9'h047);
    for (int i = 0; i < 24; i++)
      step("rand", 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
